signed_bcd_conv_v: RTL and testbench

SIGNED_BCD_CONV_V -- requirements
Module: signed_bcd_conv_v

---
 rtl/signed_bcd_conv_v.sv | 106 ++++++++++
 tb/tb_signed_bcd_conv_v.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/signed_bcd_conv_v.sv
// Signed two's-complement to sign + 3-digit BCD converter.
// Sequential double-dabble, one shift per clock, valid/ready handshake on
// both the input and output sides.
module signed_bcd_conv_v #(
  parameter int DATA_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic signed [DATA_W-1:0] i_fu,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic                     o_sign,
  output logic [3:0]               o_bcd2,
  output logic [3:0]               o_bcd1,
  output logic [3:0]               o_bcd0,
  output logic                     o_valid,
  input  logic                     i_ready
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state;
  logic                sign_r;
  logic [DATA_W-1:0]   mag;
  logic [11:0]         scratch;
  logic [CNT_W-1:0]    cnt;

  logic [DATA_W-1:0]   mag_in;
  logic [11:0]         adj;
  logic [11+DATA_W:0]  shifted;

  // Magnitude is kept unsigned so the most negative input maps to +2^(DATA_W-1).
  assign mag_in = i_fu[DATA_W-1] ? $unsigned(-i_fu) : $unsigned(i_fu);

  // Input side is open only in IDLE and never while reset is asserted.
  assign o_ready = (state == IDLE) && !i_rst;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  always_comb begin
    adj = scratch;
    for (int unsigned i = 0; i < 3; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  assign shifted = {adj, mag} << 1;

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      sign_r  <= 1'b0;
      mag     <= '0;
      scratch <= '0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_sign  <= 1'b0;
      o_bcd2  <= '0;
      o_bcd1  <= '0;
      o_bcd0  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            sign_r  <= i_fu[DATA_W-1];
            mag     <= mag_in;
            scratch <= '0;
            cnt     <= CNT_W'(DATA_W);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= shifted[11+DATA_W:DATA_W];
          mag     <= shifted[DATA_W-1:0];
          cnt     <= cnt - CNT_W'(1);
          // Results come straight from the final shift so o_valid lands on
          // the same edge as the last step.
          if (cnt == CNT_W'(1)) begin
            state   <= DONE;
            o_sign  <= sign_r;
            o_bcd2  <= shifted[11+DATA_W -: 4];
            o_bcd1  <= shifted[7+DATA_W -: 4];
            o_bcd0  <= shifted[3+DATA_W -: 4];
            o_valid <= 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_bcd_conv_v.sv
// Self-checking bench for signed_bcd_conv_v: directed corner cases plus
// random words compared against an arithmetic decimal model.
module tb_signed_bcd_conv_v;

  localparam int DATA_W = 8;

  logic                     clk;
  logic                     rst;
  logic signed [DATA_W-1:0] fu;
  logic                     in_valid;
  logic                     ready_out;
  logic                     sign;
  logic [3:0]               bcd2, bcd1, bcd0;
  logic                     valid_out;
  logic                     ready_in;

  int checks = 0;
  int errors = 0;

  signed_bcd_conv_v #(.DATA_W(DATA_W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_fu    (fu),
    .i_valid (in_valid),
    .o_ready (ready_out),
    .o_sign  (sign),
    .o_bcd2  (bcd2),
    .o_bcd1  (bcd1),
    .o_bcd0  (bcd0),
    .o_valid (valid_out),
    .i_ready (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle so inputs/outputs are away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal reference: sign and digits of |v| by plain integer arithmetic.
  task automatic ref_model(input logic [7:0] v, output int s, output int d2,
                           output int d1, output int d0);
    int x;
    int m;
    x = int'($signed(v));
    s = (x < 0) ? 1 : 0;
    m = (x < 0) ? -x : x;
    d2 = m / 100;
    d1 = (m / 10) % 10;
    d0 = m % 10;
  endtask

  task automatic chk_result(input string tag, input logic [7:0] v);
    int s, d2, d1, d0;
    ref_model(v, s, d2, d1, d0);
    chk({tag, "_sign"}, int'(sign), s);
    chk({tag, "_bcd2"}, int'(bcd2), d2);
    chk({tag, "_bcd1"}, int'(bcd1), d1);
    chk({tag, "_bcd0"}, int'(bcd0), d0);
  endtask

  // Wait (bounded) for o_valid, counting edges since acceptance.
  task automatic wait_done(input string tag, input bit noise);
    int n;
    n = 0;
    while (!valid_out && n < 40) begin
      if (noise) begin
        in_valid = 1'($urandom);
        fu       = DATA_W'($urandom);
        ready_in = 1'($urandom);
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    ready_in = 1'b0;
    chk({tag, "_latency"}, n, DATA_W);
  endtask

  // Full transaction: present v, convert, hold for `hold` cycles, release.
  task automatic convert(input string tag, input logic [7:0] v, input int hold,
                         input bit noise);
    int n;
    logic [3:0] h2, h1, h0;
    logic hs;
    n = 0;
    while (!ready_out && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_ready_wait"}, int'(ready_out), 1);
    fu       = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, int'(ready_out), 0);
    wait_done(tag, noise);
    chk({tag, "_valid"}, int'(valid_out), 1);
    chk_result(tag, v);
    hs = sign; h2 = bcd2; h1 = bcd1; h0 = bcd0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      fu       = DATA_W'($urandom);
      tick();
      chk({tag, "_hold_valid"}, int'(valid_out), 1);
      chk({tag, "_hold_ready"}, int'(ready_out), 0);
      chk({tag, "_hold_data"}, int'({hs, h2, h1, h0}),
          int'({sign, bcd2, bcd1, bcd0}));
    end
    in_valid = 1'b0;
    if (hold > 0) chk_result({tag, "_held"}, v);
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    chk({tag, "_release_valid"}, int'(valid_out), 0);
    chk({tag, "_release_ready"}, int'(ready_out), 1);
    chk_result({tag, "_kept"}, v);
  endtask

  initial begin
    logic [7:0] rv;
    rst      = 1'b1;
    fu       = '0;
    in_valid = 1'b0;
    ready_in = 1'b0;
    tick();
    tick();
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_ready", int'(ready_out), 0);
    chk("rst_data", int'({sign, bcd2, bcd1, bcd0}), 0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", int'(ready_out), 1);

    convert("zero", 8'h00, 0, 0);
    convert("p127", 8'h7F, 0, 0);
    convert("n128", 8'h80, 0, 0);
    convert("n1", 8'hFF, 0, 0);
    convert("n61", 8'hC3, 20, 0);

    // Busy input: 0x55 held on i_valid while 0x0A converts.
    fu       = 8'h0A;
    in_valid = 1'b1;
    tick();
    fu       = 8'h55;
    wait_done("busy_a", 0);
    chk_result("busy_a", 8'h0A);
    in_valid = 1'b1;
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    chk("busy_idle_ready", int'(ready_out), 1);
    tick();
    chk("busy_accept", int'(ready_out), 0);
    in_valid = 1'b0;
    wait_done("busy_b", 0);
    chk_result("busy_b", 8'h55);
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;

    // Reset in the middle of a conversion discards it.
    fu       = 8'h7B;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst      = 1'b1;
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    rst      = 1'b0;
    #1;
    chk("midrst_valid", int'(valid_out), 0);
    chk("midrst_data", int'({sign, bcd2, bcd1, bcd0}), 0);
    chk("midrst_ready", int'(ready_out), 1);
    convert("p100", 8'h64, 0, 0);

    for (int k = 0; k < 40; k++) begin
      rv = 8'($urandom);
      convert("rand", rv, int'($urandom_range(0, 3)), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end

endmodule
